// File: rtl/syzygy_dac_pkg.sv
// Shared definitions for the SYZYGY DAC sample-stream buffer: FSM encodings,
// default idle code and a width helper.
package syzygy_dac_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PREFILL = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  // Offset-binary midscale: zero output from the DAC.
  localparam logic [11:0] DEFAULT_IDLE_CODE = 12'h800;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/syzygy_dac_fifo.sv
// Synchronous FIFO with combinational head read; level is registered so
// full/empty only change on clock edges.
module syzygy_dac_fifo
  import syzygy_dac_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 1024,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  // Flush dominates both ports; a full FIFO refuses writes even while popping.
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/syzygy_dac_stream.sv
// Sample-stream buffer feeding the SYZYGY DAC PHY: buffers packed I/Q words,
// plays one pair per clock once armed and prefilled, counts starved cycles.
module syzygy_dac_stream
  import syzygy_dac_pkg::*;
#(
  parameter int                DATA_W    = 12,
  parameter int                DEPTH     = 1024,
  parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(DEFAULT_IDLE_CODE),
  parameter int                AW        = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2*DATA_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                start,
  input  logic                stop,
  input  logic                flush,
  input  logic [AW:0]         prefill,
  output logic [DATA_W-1:0]   data_i,
  output logic [DATA_W-1:0]   data_q,
  output logic                running,
  output logic [AW:0]         fifo_level,
  output logic [15:0]         underrun_count
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [1:0]          state, state_nxt;
  logic [2*DATA_W-1:0] head;
  logic                full, empty, push, pop, starve;
  logic [AW:0]         prefill_eff;

  assign s_ready     = !full && !flush;
  assign push        = s_valid && s_ready;
  assign pop         = (state == RUN) && !stop && !empty;
  assign starve      = (state == RUN) && !stop && empty;
  assign running     = (state == RUN);
  assign prefill_eff = (prefill > FULL_LVL) ? FULL_LVL : prefill;

  syzygy_dac_fifo #(.W(2*DATA_W), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (push),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_data (head),
    .level   (fifo_level),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_nxt = state;
    if (stop) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_nxt = PREFILL;
        PREFILL: if (fifo_level >= prefill_eff) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      data_i         <= IDLE_CODE;
      data_q         <= IDLE_CODE;
      underrun_count <= '0;
    end else begin
      state  <= state_nxt;
      data_i <= pop ? head[DATA_W-1:0]        : IDLE_CODE;
      data_q <= pop ? head[2*DATA_W-1:DATA_W] : IDLE_CODE;
      // Count survives stop for status readback; a fresh arm clears it.
      if ((state == IDLE) && start && !stop)
        underrun_count <= '0;
      else if (starve && (underrun_count != 16'hFFFF))
        underrun_count <= underrun_count + 16'd1;
    end
  end

endmodule
